// File: rtl/load_store_buffer_unit.sv
// Load/store unit with a circular store buffer. Loads that hit a buffered
// store are forwarded from the youngest matching entry. Loads that miss go
// to memory ahead of the buffered stores. The buffer drains one write at a
// time whenever the unit is idle and no load is being accepted.
module load_store_buffer_unit #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [AW-1:0]            st_addr,
    input  logic [DW-1:0]            st_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [AW-1:0]            ld_addr,
    output logic                     ld_resp_valid,
    output logic [DW-1:0]            ld_resp_data,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_we,
    output logic [AW-1:0]            mem_req_addr,
    output logic [DW-1:0]            mem_req_wdata,
    input  logic                     mem_rsp_valid,
    input  logic [DW-1:0]            mem_rsp_data,
    output logic [$clog2(DEPTH):0]   sb_count,
    output logic                     sb_full,
    output logic                     sb_empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ST_REQ, LD_REQ, LD_WAIT} state_t;

    state_t          state;
    logic [AW-1:0]   sb_addr [DEPTH];
    logic [DW-1:0]   sb_data [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic            push;
    logic            pop;
    logic            ld_acc;
    logic            fwd_hit;
    logic [DW-1:0]   fwd_data;

    assign sb_full  = (sb_count == CW'(DEPTH));
    assign sb_empty = (sb_count == '0);
    assign st_ready = !sb_full;
    assign ld_ready = (state == IDLE);
    assign push     = st_valid && st_ready;
    assign ld_acc   = ld_valid && ld_ready;
    assign pop      = (state == ST_REQ) && mem_req_ready;

    // Forwarding lookup: scan oldest to youngest over valid entries so the
    // youngest match is the one left standing.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < sb_count) && (sb_addr[head + PW'(k)] == ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data[head + PW'(k)];
            end
        end
    end

    // Store buffer entry storage; validity comes from head/count only.
    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr[tail] <= st_addr;
            sb_data[tail] <= st_data;
        end
    end

    // Buffer pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            sb_count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   sb_count <= sb_count + CW'(1);
                2'b01:   sb_count <= sb_count - CW'(1);
                default: sb_count <= sb_count;
            endcase
        end
    end

    // Control FSM with registered memory request and load response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ld_resp_valid <= 1'b0;
            ld_resp_data  <= '0;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
        end else begin
            ld_resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld_acc) begin
                        if (fwd_hit) begin
                            ld_resp_valid <= 1'b1;
                            ld_resp_data  <= fwd_data;
                        end else begin
                            state         <= LD_REQ;
                            mem_req_valid <= 1'b1;
                            mem_req_we    <= 1'b0;
                            mem_req_addr  <= ld_addr;
                        end
                    end else if (!sb_empty) begin
                        state         <= ST_REQ;
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= 1'b1;
                        mem_req_addr  <= sb_addr[head];
                        mem_req_wdata <= sb_data[head];
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        state         <= IDLE;
                        mem_req_valid <= 1'b0;
                    end
                end
                LD_REQ: begin
                    if (mem_req_ready) begin
                        state         <= LD_WAIT;
                        mem_req_valid <= 1'b0;
                    end
                end
                LD_WAIT: begin
                    if (mem_rsp_valid) begin
                        state         <= IDLE;
                        ld_resp_valid <= 1'b1;
                        ld_resp_data  <= mem_rsp_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_buffer_unit.sv
// Bench for load_store_buffer_unit: queue-based reference model checked
// every cycle, a simple memory responder, and directed scenarios with
// hand-computed expectations.
module tb_load_store_buffer_unit;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk;
    logic            reset;
    logic            st_valid;
    logic            st_ready;
    logic [AW-1:0]   st_addr;
    logic [DW-1:0]   st_data;
    logic            ld_valid;
    logic            ld_ready;
    logic [AW-1:0]   ld_addr;
    logic            ld_resp_valid;
    logic [DW-1:0]   ld_resp_data;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_req_we;
    logic [AW-1:0]   mem_req_addr;
    logic [DW-1:0]   mem_req_wdata;
    logic            mem_rsp_valid;
    logic [DW-1:0]   mem_rsp_data;
    logic [CW-1:0]   sb_count;
    logic            sb_full;
    logic            sb_empty;

    load_store_buffer_unit #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .sb_count(sb_count), .sb_full(sb_full), .sb_empty(sb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          m_q[$];
    int            m_phase;          // 0 idle, 1 draining, 2 load request, 3 load wait
    logic          m_mreq_v;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_resp_v;
    logic [DW-1:0] m_resp_d;
    logic          m_st_acc;
    logic          m_ld_acc;
    logic          m_hit;
    logic [DW-1:0] m_hd;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_phase  = 0;
            m_mreq_v = 1'b0;
            m_we     = 1'b0;
            m_addr   = '0;
            m_wdata  = '0;
            m_resp_v = 1'b0;
            m_resp_d = '0;
        end else begin
            m_st_acc = st_valid && (m_q.size() < DEPTH);
            m_ld_acc = ld_valid && (m_phase == 0);
            m_resp_v = 1'b0;
            case (m_phase)
                0: begin
                    if (m_ld_acc) begin
                        m_hit = 1'b0;
                        m_hd  = '0;
                        for (int i = int'(m_q.size()) - 1; i >= 0; i--) begin
                            if (!m_hit && m_q[i].a == ld_addr) begin
                                m_hit = 1'b1;
                                m_hd  = m_q[i].d;
                            end
                        end
                        if (m_hit) begin
                            m_resp_v = 1'b1;
                            m_resp_d = m_hd;
                        end else begin
                            m_phase  = 2;
                            m_mreq_v = 1'b1;
                            m_we     = 1'b0;
                            m_addr   = ld_addr;
                        end
                    end else if (m_q.size() > 0) begin
                        m_phase  = 1;
                        m_mreq_v = 1'b1;
                        m_we     = 1'b1;
                        m_addr   = m_q[0].a;
                        m_wdata  = m_q[0].d;
                    end
                end
                1: if (mem_req_ready) begin
                    void'(m_q.pop_front());
                    m_phase  = 0;
                    m_mreq_v = 1'b0;
                end
                2: if (mem_req_ready) begin
                    m_phase  = 3;
                    m_mreq_v = 1'b0;
                end
                default: if (mem_rsp_valid) begin
                    m_phase  = 0;
                    m_resp_v = 1'b1;
                    m_resp_d = mem_rsp_data;
                end
            endcase
            if (m_st_acc) m_q.push_back('{a: st_addr, d: st_data});
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("sb_count", 64'(sb_count), 64'(m_q.size()));
        chk("sb_full", 64'(sb_full), 64'(m_q.size() == DEPTH));
        chk("sb_empty", 64'(sb_empty), 64'(m_q.size() == 0));
        chk("st_ready", 64'(st_ready), 64'(m_q.size() < DEPTH));
        chk("ld_ready", 64'(ld_ready), 64'(m_phase == 0));
        chk("mem_req_valid", 64'(mem_req_valid), 64'(m_mreq_v));
        if (m_mreq_v || reset) begin
            chk("mem_req_we", 64'(mem_req_we), 64'(m_we));
            chk("mem_req_addr", 64'(mem_req_addr), 64'(m_addr));
        end
        if ((m_mreq_v && m_we) || reset)
            chk("mem_req_wdata", 64'(mem_req_wdata), 64'(m_wdata));
        chk("ld_resp_valid", 64'(ld_resp_valid), 64'(m_resp_v));
        if (m_resp_v || reset)
            chk("ld_resp_data", 64'(ld_resp_data), 64'(m_resp_d));
    end

    // ---------------- monitors and memory ----------------
    int            resp_cnt = 0;
    logic [DW-1:0] last_resp = '0;
    logic [AW:0]   op_log[$];        // {we, addr} per accepted memory request
    logic [DW-1:0] mem [logic [AW-1:0]];
    int            rsp_delay = 3;
    int            rsp_sent = 0;

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return DW'(a + 32'h35);
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (ld_resp_valid) begin
                resp_cnt++;
                last_resp = ld_resp_data;
            end
            if (mem_req_valid && mem_req_ready) begin
                op_log.push_back({mem_req_we, mem_req_addr});
                if (mem_req_we) mem[mem_req_addr] = mem_req_wdata;
            end
        end
    end

    // Read responder: answers each accepted read rsp_delay edges later.
    initial begin : responder
        logic [AW-1:0] ra;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (!reset && mem_req_valid && mem_req_ready && !mem_req_we) begin
                ra = mem_req_addr;
                @(posedge clk);
                repeat (rsp_delay - 1) @(posedge clk);
                #1;
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = mem_rd(ra);
                rsp_sent++;
                @(posedge clk);
                #1;
                mem_rsp_valid = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic rdy;
        logic ok;
        ok = 1'b0;
        st_valid = 1'b1; st_addr = a; st_data = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk); rdy = st_ready;
            @(posedge clk); #1;
            if (rdy) ok = 1'b1;
        end
        st_valid = 1'b0;
        if (!ok) chk("store_accept_timeout", 64'(ok), 64'(1));
    endtask

    task automatic do_load(input logic [AW-1:0] a);
        logic rdy;
        logic ok;
        ok = 1'b0;
        ld_valid = 1'b1; ld_addr = a;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk); rdy = ld_ready;
            @(posedge clk); #1;
            if (rdy) ok = 1'b1;
        end
        ld_valid = 1'b0;
        if (!ok) chk("load_accept_timeout", 64'(ok), 64'(1));
    endtask

    task automatic wait_resp(input int base);
        for (int i = 0; i < 40 && resp_cnt == base; i++) begin
            @(posedge clk); #1;
        end
        chk("resp_arrived", 64'(resp_cnt > base), 64'(1));
    endtask

    task automatic wait_quiet();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(posedge clk); #1;
            if (sb_empty && ld_ready && !mem_req_valid) ok = 1'b1;
        end
        chk("quiet_reached", 64'(ok), 64'(1));
    endtask

    function automatic int count_ops(input logic we);
        int n = 0;
        foreach (op_log[i]) if (op_log[i][AW] == we) n++;
        return n;
    endfunction

    // Store and load offered in the same cycle from an idle, empty unit.
    task automatic store_and_load(input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                                  input logic [AW-1:0] la, input logic [DW-1:0] exp_rsp);
        logic sr, lr;
        int   r0;
        op_log.delete();
        r0 = resp_cnt;
        st_valid = 1'b1; st_addr = sa; st_data = sd;
        ld_valid = 1'b1; ld_addr = la;
        @(negedge clk); sr = st_ready; lr = ld_ready;
        @(posedge clk); #1;
        st_valid = 1'b0; ld_valid = 1'b0;
        chk("sl_store_accepted", 64'(sr), 64'(1));
        chk("sl_load_accepted", 64'(lr), 64'(1));
        wait_resp(r0);
        chk("sl_resp_data", 64'(last_resp), 64'(exp_rsp));
        wait_quiet();
        chk("sl_op_count", 64'(op_log.size()), 64'(2));
        if (op_log.size() == 2) begin
            chk("sl_first_is_read", 64'(op_log[0]), 64'({1'b0, la}));
            chk("sl_then_write", 64'(op_log[1]), 64'({1'b1, sa}));
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int r0;
        int sent0;
        logic rdy;
        logic ok;
        int   iters;

        st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_addr = '0;
        mem_req_ready = 1'b1;
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sb_empty", 64'(sb_empty), 64'(1));
        chk("rst_sb_count", 64'(sb_count), 64'(0));
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
        chk("rst_ld_resp_data", 64'(ld_resp_data), 64'(0));
        chk("rst_ld_ready", 64'(ld_ready), 64'(1));
        reset = 1'b0;
        @(posedge clk); #1;

        // Forward hit straight after a store, no memory read.
        op_log.delete();
        do_store(32'h10, 32'hAA);
        do_load(32'h10);
        chk("fwd_valid_next_cycle", 64'(ld_resp_valid), 64'(1));
        chk("fwd_data_aa", 64'(ld_resp_data), 64'(32'hAA));
        wait_quiet();
        chk("fwd_no_mem_read", 64'(count_ops(1'b0)), 64'(0));

        // Youngest of two matching entries wins.
        mem_req_ready = 1'b0;
        do_store(32'h50, 32'h99);
        do_store(32'h10, 32'h1);
        do_store(32'h10, 32'h2);
        mem_req_ready = 1'b1;
        do_load(32'h10);
        chk("youngest_valid", 64'(ld_resp_valid), 64'(1));
        chk("youngest_data", 64'(ld_resp_data), 64'(32'h2));
        wait_quiet();

        // Full buffer back-pressure; fifth store waits for a pop.
        op_log.delete();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_store(32'h100 + 32'(i), 32'hC0 + 32'(i));
        chk("full_count", 64'(sb_count), 64'(4));
        chk("full_flag", 64'(sb_full), 64'(1));
        chk("full_st_ready", 64'(st_ready), 64'(0));
        st_valid = 1'b1; st_addr = 32'h104; st_data = 32'hC4;
        repeat (3) begin @(posedge clk); #1; end
        chk("full_still_4", 64'(sb_count), 64'(4));
        mem_req_ready = 1'b1;
        ok = 1'b0; iters = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk); rdy = st_ready;
            @(posedge clk); #1;
            iters++;
            if (rdy) ok = 1'b1;
        end
        st_valid = 1'b0;
        chk("fifth_accepted", 64'(ok), 64'(1));
        chk("fifth_after_pop", 64'(iters), 64'(2));
        wait_quiet();
        chk("drained_writes", 64'(count_ops(1'b1)), 64'(5));

        // Miss from an empty buffer goes to memory.
        op_log.delete();
        rsp_delay = 3;
        r0 = resp_cnt;
        do_load(32'h20);
        wait_resp(r0);
        chk("miss_data", 64'(last_resp), 64'(32'h55));
        chk("miss_req", 64'(op_log.size() > 0 ? op_log[0] : '0), 64'({1'b0, 32'h20}));
        repeat (5) begin @(posedge clk); #1; end
        chk("miss_single_pulse", 64'(resp_cnt), 64'(r0 + 1));

        // Load served before the buffered write; count drops after drain.
        store_and_load(32'h30, 32'h77, 32'h40, 32'h75);
        // Same-cycle store to the load address is not forwarded.
        store_and_load(32'h60, 32'h11, 32'h60, 32'h95);

        // Reset during LD_WAIT; the late response must be ignored.
        rsp_delay = 6;
        r0 = resp_cnt;
        sent0 = rsp_sent;
        do_load(32'h70);
        @(posedge clk); #1;
        chk("lw_not_ready", 64'(ld_ready), 64'(0));
        reset = 1'b1;
        #1;
        chk("lw_rst_req_valid", 64'(mem_req_valid), 64'(0));
        chk("lw_rst_req_addr", 64'(mem_req_addr), 64'(0));
        chk("lw_rst_resp_valid", 64'(ld_resp_valid), 64'(0));
        chk("lw_rst_ld_ready", 64'(ld_ready), 64'(1));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        chk("lw_late_rsp_sent", 64'(rsp_sent), 64'(sent0 + 1));
        chk("lw_no_resp", 64'(resp_cnt), 64'(r0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
